peripheral_mpram_ahb3_slave: RTL
================================

// Module: peripheral_mpram_ahb3_slave
//
// PURPOSE
// - AHB3-Lite slave front-end. Drives the 1R1W inferred RAM (peripheral_mpram_1r1w_generic).
// - Converts AHB address/data phases into RAM read/write strobes, with zero wait states on OKAY transfers.
// - RAM reads are registered (1-cycle latency), so read data arrives exactly in the AHB data phase.
// - Write-then-read to the same word is resolved by a bypass. It never stalls.
// - Illegal transfers get the two-cycle AHB ERROR response.
//
// PARAMETERS
// - HADDR_SIZE  32  AHB address width.
// - HDATA_SIZE  32  AHB data width. Also the RAM DBITS. Must be 8, 16, 32 or 64.
// - MEM_ABITS   10  RAM word-address width (ABITS). Upper HADDR bits are ignored, so the address wraps.
//
// PORTS
// Clock and reset:
// - clk_i              in   1            Single clock.
// - rst_ni             in   1            Asynchronous, active-low reset.
// AHB side:
// - ahb3_hsel_i        in   1            Slave select.
// - ahb3_haddr_i       in   HADDR_SIZE   Address.
// - ahb3_hwdata_i      in   HDATA_SIZE   Write data (data phase).
// - ahb3_hrdata_o      out  HDATA_SIZE   Read data (data phase).
// - ahb3_hwrite_i      in   1            1 = write.
// - ahb3_hsize_i       in   3            Transfer size.
// - ahb3_hburst_i      in   3            Burst type. Ignored; every beat is decoded individually.
// - ahb3_hprot_i       in   4            Ignored.
// - ahb3_htrans_i      in   2            IDLE/BUSY/NONSEQ/SEQ.
// - ahb3_hmastlock_i   in   1            Ignored.
// - ahb3_hreadyout_o   out  1            Slave ready.
// - ahb3_hready_i      in   1            Global HREADY.
// - ahb3_hresp_o       out  1            0 = OKAY, 1 = ERROR.
// RAM side:
// - waddr_o            out  MEM_ABITS    RAM write word address.
// - din_o              out  HDATA_SIZE   RAM write data.
// - we_o               out  1            RAM write enable.
// - be_o               out  HDATA_SIZE/8 RAM byte enables.
// - raddr_o            out  MEM_ABITS    RAM read word address.
// - dout_i             in   HDATA_SIZE   RAM read data (1-cycle registered).
//
// BEHAVIOUR
// Address phase accepted:
// - acc = hsel & hready_i & htrans in {NONSEQ, SEQ}.
// - IDLE or BUSY: OKAY, zero wait, no RAM access.
// Address decode:
// - Word address = haddr[MEM_ABITS+LB-1 : LB], where LB = log2(HDATA_SIZE/8).
// - be = ((1 << (1 << hsize)) - 1) << haddr[LB-1:0].
// Illegal (decided in address phase), either of:
// - hsize > LB;
// - haddr not aligned to the transfer size.
// Read path:
// - raddr_o is driven combinationally from the haddr word bits every cycle; reads have no side effects.
// - hrdata_o is taken from dout_i in the read data phase.
// Write path:
// - On acc & hwrite & legal: latch waddr, be and wr_pend = 1.
// - In the next cycle (data phase): we_o = wr_pend, waddr_o/be_o come from the latches, din_o = hwdata_i.
// - The write commits at the end of the data phase. Lanes with be = 0 are left unchanged.
// Bypass:
// - Condition: a read is accepted in the same cycle that wr_pend = 1, and its word address equals waddr_o.
// - The RAM returns the old data in that case, so register byp_hit = 1, byp_data = hwdata_i, byp_be = be_o.
// - Next cycle: each hrdata byte k = (byp_hit & byp_be[k]) ? byp_data[k] : dout_i[k].
// - byp_hit clears after one cycle.
// FSM states (state register):
// - OK: hreadyout = 1, hresp = 0.
// - ERR1: hreadyout = 0, hresp = 1.
// - ERR2: hreadyout = 1, hresp = 1.
// FSM transitions:
// - OK -> ERR1 on acc & illegal.
// - ERR1 -> ERR2 unconditionally.
// - ERR2 -> OK. If a new acc is present in ERR2, it is decoded normally; an illegal one goes to ERR1 again.
// - An illegal transfer never asserts we_o and never sets byp_hit.
// hready_i low (another slave is stretching):
// - No address phase is sampled.
// - A pending write still commits in the current cycle, because our own data phase is already complete.
// Back-to-back writes:
// - Each write commits in its own data phase.
// - Same-word writes are ordered and later bytes win.
// Reset (asynchronous, any time):
// - state = OK, wr_pend = 0, byp_hit = 0.
// - Outputs: we_o = 0, be_o = 0, waddr_o = 0, hreadyout = 1, hresp = 0.
// - A write whose data phase is cut by reset is dropped.
// - hrdata_o is don't-care outside read data phases.
//
// STRUCTURE
// - peripheral_ahb3_pkg holds:
//   - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
//   - HSIZE_BYTE..HSIZE_DWORD;
//   - HRESP_OKAY/ERROR;
//   - the state enum;
//   - the byte-enable function gen_be(hsize, addr_lsb).
// - No sub-module. A top wrapper peripheral_mpram_ahb3 instantiates this block plus peripheral_mpram_1r1w_generic.
//
// TESTING (bench = this block plus the generic RAM, HDATA_SIZE = 32)
// 1. Write word 0x0000_0010 = 0xDEAD_BEEF, then read 0x10 two cycles later:
//    - hrdata = 0xDEAD_BEEF, zero wait, OKAY.
// 2. Byte write 0xAA to 0x13 over a word holding 0x1122_3344:
//    - be_o = 4'b1000;
//    - the read returns 0xAA22_3344.
// 3. Write 0x0000_0020 = 0xCAFE_F00D immediately followed by a read of 0x20 (address phase overlaps the write data phase):
//    - the bypass returns 0xCAFE_F00D, no wait state.
// 4. Halfword write 0x5566 to 0x22, then read 0x20:
//    - bypass merges the upper lanes only, giving 0x5566_F00D.
// 5. Read with hsize = WORD at 0x21 (misaligned), and a write with hsize = DWORD:
//    - each gives ERROR 2 cycles (hreadyout 0 then 1), we_o stays 0;
//    - a following legal read is OKAY.
// 6. Assert rst_ni low during a write data phase:
//    - we_o drops to 0 immediately, the word is unchanged;
//    - after release: hreadyout = 1, hresp = 0.
//    Also check: address 0x1000 (MEM_ABITS = 10) wraps to word 0.

Source files
------------

// File: rtl/peripheral_ahb3_pkg.sv
// Shared AHB3-Lite encodings, the slave response state type and the
// byte-enable helper used by the MPRAM AHB front-end.
package peripheral_ahb3_pkg;

   // HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // HSIZE encodings (only the ones a <=64-bit bus can legally carry)
   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   // HRESP encodings
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Response state: OK, first ERROR cycle (wait), second ERROR cycle (ready)
   typedef enum logic [1:0] {
      ST_OK   = 2'b00,
      ST_ERR1 = 2'b01,
      ST_ERR2 = 2'b10
   } ahb_state_e;

   // Byte enables for a transfer of 2**hsize bytes starting at byte lane
   // addr_lsb, on a bus of up to 8 byte lanes. Narrower buses take the low bits.
   function automatic logic [7:0] gen_be(input logic [2:0] hsize,
                                         input logic [2:0] addr_lsb);
      logic [7:0] mask;
      case (hsize)
         HSIZE_BYTE:  mask = 8'h01;
         HSIZE_HWORD: mask = 8'h03;
         HSIZE_WORD:  mask = 8'h0F;
         default:     mask = 8'hFF;
      endcase
      return mask << addr_lsb;
   endfunction

endpackage

// File: rtl/peripheral_mpram_1r1w_generic.sv
// Inferred simple dual-port RAM: one write port with byte enables, one read
// port with a registered output. A same-cycle read of the word being written
// returns the old contents; the AHB front-end bypasses around that.
module peripheral_mpram_1r1w_generic #(
   parameter int ABITS = 10,
   parameter int DBITS = 32
) (
   input  logic               clk_i,
   input  logic [ABITS-1:0]   waddr_i,
   input  logic [DBITS-1:0]   din_i,
   input  logic               we_i,
   input  logic [DBITS/8-1:0] be_i,
   input  logic [ABITS-1:0]   raddr_i,
   output logic [DBITS-1:0]   dout_o
);

   localparam int BE_W = DBITS / 8;

   logic [DBITS-1:0] mem_q [2**ABITS];

   // Byte-masked write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int k = 0; k < BE_W; k++) begin
            if (be_i[k]) mem_q[waddr_i][k*8 +: 8] <= din_i[k*8 +: 8];
         end
      end
   end

   // Registered read port (read-before-write on collision)
   always_ff @(posedge clk_i) begin
      dout_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/peripheral_mpram_ahb3_slave.sv
// AHB3-Lite slave front-end for the 1R1W inferred RAM. Zero wait states on
// OKAY transfers; writes are issued in their data phase; a read that hits
// the word being written in the same cycle is served from a bypass register;
// illegal transfers get the two-cycle ERROR response.
module peripheral_mpram_ahb3_slave
   import peripheral_ahb3_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MEM_ABITS  = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // AHB side
   input  logic                    ahb3_hsel_i,
   input  logic [HADDR_SIZE-1:0]   ahb3_haddr_i,
   input  logic [HDATA_SIZE-1:0]   ahb3_hwdata_i,
   output logic [HDATA_SIZE-1:0]   ahb3_hrdata_o,
   input  logic                    ahb3_hwrite_i,
   input  logic [2:0]              ahb3_hsize_i,
   input  logic [2:0]              ahb3_hburst_i,
   input  logic [3:0]              ahb3_hprot_i,
   input  logic [1:0]              ahb3_htrans_i,
   input  logic                    ahb3_hmastlock_i,
   output logic                    ahb3_hreadyout_o,
   input  logic                    ahb3_hready_i,
   output logic                    ahb3_hresp_o,
   // RAM side
   output logic [MEM_ABITS-1:0]    waddr_o,
   output logic [HDATA_SIZE-1:0]   din_o,
   output logic                    we_o,
   output logic [HDATA_SIZE/8-1:0] be_o,
   output logic [MEM_ABITS-1:0]    raddr_o,
   input  logic [HDATA_SIZE-1:0]   dout_i
);

   localparam int BE_W = HDATA_SIZE / 8;
   localparam int LB   = $clog2(BE_W);

   // Handshake: an address phase is taken only when hsel, the global HREADY
   // and an active HTRANS (NONSEQ/SEQ) coincide; the data phase that follows
   // always completes with zero wait states unless the transfer was illegal,
   // in which case hreadyout is held low for exactly one ERROR cycle.

   ahb_state_e state_q, state_d;

   logic                 wr_pend_q, wr_pend_d;
   logic [MEM_ABITS-1:0] waddr_q, waddr_d;
   logic [BE_W-1:0]      be_q, be_d;
   logic                 byp_hit_q, byp_hit_d;
   logic [HDATA_SIZE-1:0] byp_data_q, byp_data_d;
   logic [BE_W-1:0]      byp_be_q, byp_be_d;

   logic                 acc;
   logic                 illegal;
   logic                 too_big;
   logic                 misaligned;
   logic [2:0]           addr_lsb;
   logic [7:0]           size_mask;
   logic [7:0]           be_full;
   logic [BE_W-1:0]      be_new;
   logic [MEM_ABITS-1:0] word_addr;
   logic                 unused_sig;

   // Byte-lane offset inside a bus word; an 8-bit bus has none.
   if (LB == 0) begin : g_lsb_none
      assign addr_lsb = 3'd0;
   end else begin : g_lsb
      assign addr_lsb = 3'(ahb3_haddr_i[LB-1:0]);
   end

   // Upper HADDR bits fall off here, so the address space wraps on the RAM.
   assign word_addr  = ahb3_haddr_i[MEM_ABITS+LB-1:LB];
   assign acc        = ahb3_hsel_i & ahb3_hready_i &
                       ((ahb3_htrans_i == HTRANS_NONSEQ) | (ahb3_htrans_i == HTRANS_SEQ));
   assign size_mask  = (8'd1 << ahb3_hsize_i) - 8'd1;
   assign misaligned = |({5'd0, addr_lsb} & size_mask);
   assign too_big    = ahb3_hsize_i > 3'(LB);
   assign illegal    = too_big | misaligned;
   assign be_full    = gen_be(ahb3_hsize_i, addr_lsb);
   assign be_new     = be_full[BE_W-1:0];

   // Reads have no side effects, so the RAM read address simply follows HADDR.
   assign raddr_o = word_addr;
   assign waddr_o = waddr_q;
   assign be_o    = be_q;
   assign we_o    = wr_pend_q;
   assign din_o   = ahb3_hwdata_i;

   assign unused_sig = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i,
                         ahb3_haddr_i, be_full};

   // Response state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_OK;
      else         state_q <= state_d;
   end

   // Response next-state and HREADYOUT/HRESP decode
   always_comb begin
      state_d          = state_q;
      ahb3_hreadyout_o = 1'b1;
      ahb3_hresp_o     = HRESP_OKAY;
      case (state_q)
         ST_OK: begin
            if (acc && illegal) state_d = ST_ERR1;
         end
         ST_ERR1: begin
            ahb3_hreadyout_o = 1'b0;
            ahb3_hresp_o     = HRESP_ERROR;
            state_d          = ST_ERR2;
         end
         ST_ERR2: begin
            ahb3_hresp_o = HRESP_ERROR;
            state_d      = (acc && illegal) ? ST_ERR1 : ST_OK;
         end
         default: state_d = ST_OK;
      endcase
   end

   // Address-phase decode: latch legal writes, arm the bypass on a
   // read that targets the word whose write is committing this cycle.
   always_comb begin
      wr_pend_d  = 1'b0;
      waddr_d    = waddr_q;
      be_d       = be_q;
      byp_hit_d  = 1'b0;
      byp_data_d = byp_data_q;
      byp_be_d   = byp_be_q;
      if (acc && !illegal) begin
         if (ahb3_hwrite_i) begin
            wr_pend_d = 1'b1;
            waddr_d   = word_addr;
            be_d      = be_new;
         end else if (wr_pend_q && (word_addr == waddr_q)) begin
            byp_hit_d  = 1'b1;
            byp_data_d = ahb3_hwdata_i;
            byp_be_d   = be_q;
         end
      end
   end

   // Write latches and bypass registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_pend_q  <= 1'b0;
         waddr_q    <= '0;
         be_q       <= '0;
         byp_hit_q  <= 1'b0;
         byp_data_q <= '0;
         byp_be_q   <= '0;
      end else begin
         wr_pend_q  <= wr_pend_d;
         waddr_q    <= waddr_d;
         be_q       <= be_d;
         byp_hit_q  <= byp_hit_d;
         byp_data_q <= byp_data_d;
         byp_be_q   <= byp_be_d;
      end
   end

   // Read data: per-lane merge of bypassed write bytes over the RAM output
   always_comb begin
      ahb3_hrdata_o = dout_i;
      for (int k = 0; k < BE_W; k++) begin
         if (byp_hit_q && byp_be_q[k]) ahb3_hrdata_o[k*8 +: 8] = byp_data_q[k*8 +: 8];
      end
   end

endmodule
